update_packer: RTL and testbench

- Consumer stage placed directly behind the valid-compaction sorter.
- Each accepted beat carries LANES words with per-lane valid flags; valid lanes are contiguous at the high-index end.
- The block appends the valid words to a residual buffer and emits only full LANES-word lines to the memory writer.
- On the last input beat it flushes the partial line with a mask, so the update stream ends with a tagged final line.

---
 rtl/update_packer_pkg.sv | 13 +
 rtl/lane_compactor_count.sv | 16 +
 rtl/update_packer.sv | 137 +++++++++++++
 tb/tb_update_packer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/update_packer_pkg.sv
// update_packer_pkg: shared sizes, state encoding and mask helper for the update packer
package update_packer_pkg;
  localparam int LANES = 8;
  localparam int WIDTH = 32;
  localparam int LW = $clog2(LANES);
  localparam int FILL_W = LW + 1;
  localparam int CTRL_W = 2;
  typedef enum logic [0:0] {RUN, FLUSH} state_e;
  function automatic logic [LANES-1:0] low_mask(input int n);
    low_mask = '0;
    for (int i = 0; i < LANES; i++) low_mask[i] = (i < n);
  endfunction
endpackage

// File: rtl/lane_compactor_count.sv
// lane_compactor_count: popcount of the lane valid flags and high-end contiguity check
module lane_compactor_count
  import update_packer_pkg::*;
(
  input  logic [LANES-1:0]  valid_i,
  output logic [FILL_W-1:0] k_o,
  output logic              contig_o
);
  // count valid lanes; any valid lane sitting below an invalid one breaks contiguity
  always_comb begin
    k_o = '0;
    contig_o = 1'b1;
    for (int i = 0; i < LANES; i++) k_o = k_o + FILL_W'(valid_i[i]);
    for (int i = 0; i < LANES - 1; i++) if (valid_i[i] && !valid_i[i+1]) contig_o = 1'b0;
  end
endmodule

// File: rtl/update_packer.sv
// update_packer: appends valid lane words to a residual buffer and emits full lines plus a masked final line
module update_packer
  import update_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] word_in,
  input  logic [LANES-1:0]       valid_in,
  input  logic                   last_input_in,
  input  logic [CTRL_W-1:0]      control_in,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_last,
  output logic [CTRL_W-1:0]      control_out,
  output logic [31:0]            line_cnt,
  output logic                   err_noncontig
);
  state_e                 state_q, state_d;
  logic [FILL_W-1:0]      fill_q, fill_d, k;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d, oc_q, oc_d;
  logic [WIDTH-1:0]       buf_q [2*LANES];
  logic [WIDTH-1:0]       buf_d [2*LANES];
  logic [WIDTH-1:0]       buf_ext [2*LANES];
  logic [WIDTH-1:0]       comp [LANES];
  logic                   ov_q, ov_d, ol_q, ol_d, err_q, err_d, contig, accept, emit, shift;
  logic [LANES*WIDTH-1:0] od_q, od_d;
  logic [LANES-1:0]       om_q, om_d;
  logic [31:0]            cnt_q, cnt_d;
  int                     idx, total, n_emit;

  lane_compactor_count u_cnt (.valid_i(valid_in), .k_o(k), .contig_o(contig));

  assign accept = in_valid && (state_q == RUN);
  assign in_ready = (state_q == RUN);
  assign total = int'(fill_q) + int'(k);
  assign out_valid = ov_q;
  assign out_data = od_q;
  assign out_mask = om_q;
  assign out_last = ol_q;
  assign control_out = oc_q;
  assign line_cnt = cnt_q;
  assign err_noncontig = err_q;

  // gather valid lanes in ascending order and drop them into the buffer at the fill point
  always_comb begin
    comp = '{default: '0};
    idx = 0;
    for (int i = 0; i < LANES; i++)
      if (valid_in[i]) begin
        comp[LW'(idx)] = word_in[i*WIDTH +: WIDTH];
        idx++;
      end
    for (int j = 0; j < 2*LANES; j++)
      buf_ext[j] = (accept && j >= int'(fill_q) && j < total) ? comp[LW'(j - int'(fill_q))] : buf_q[j];
  end

  // next-state: line emission, residual shift, flush sequencing and status
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    ctrl_d = ctrl_q;
    buf_d = buf_ext;
    ov_d = 1'b0;
    od_d = od_q;
    om_d = om_q;
    ol_d = ol_q;
    oc_d = oc_q;
    err_d = err_q;
    emit = 1'b0;
    shift = 1'b0;
    n_emit = 0;
    if (state_q == FLUSH) begin
      emit = 1'b1;
      n_emit = int'(fill_q);
      ol_d = 1'b1;
      fill_d = '0;
      state_d = RUN;
    end else if (accept) begin
      ctrl_d = control_in;
      err_d = err_q | !contig;
      if (total >= LANES) begin
        emit = 1'b1;
        shift = 1'b1;
        n_emit = LANES;
        fill_d = FILL_W'(total - LANES);
        ol_d = last_input_in && (total == LANES);
        state_d = (last_input_in && total > LANES) ? FLUSH : RUN;
      end else if (last_input_in) begin
        emit = 1'b1;
        n_emit = total;
        ol_d = 1'b1;
        fill_d = '0;
      end else fill_d = FILL_W'(total);
    end
    if (emit) begin
      ov_d = 1'b1;
      om_d = low_mask(n_emit);
      oc_d = (state_q == FLUSH) ? ctrl_q : control_in;
      for (int j = 0; j < LANES; j++) od_d[j*WIDTH +: WIDTH] = om_d[j] ? buf_ext[j] : '0;
    end
    if (shift) for (int j = 0; j < LANES; j++) buf_d[j] = buf_ext[j+LANES];
    cnt_d = cnt_q + 32'(ov_d);
  end

  // control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fill_q <= '0;
      ctrl_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
      om_q <= '0;
      ol_q <= 1'b0;
      oc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      ctrl_q <= ctrl_d;
      ov_q <= ov_d;
      od_q <= od_d;
      om_q <= om_d;
      ol_q <= ol_d;
      oc_q <= oc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // word storage needs no reset: slots at or above fill are never read
  always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_update_packer.sv
// tb_update_packer: directed checks of packing, flush, empty final line, contiguity error and async reset
module tb_update_packer;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] word_in = '0;
  logic [7:0]   valid_in = '0;
  logic         last_input_in = 1'b0;
  logic [1:0]   control_in = '0;
  logic         out_valid;
  logic [255:0] out_data;
  logic [7:0]   out_mask;
  logic         out_last;
  logic [1:0]   control_out;
  logic [31:0]  line_cnt;
  logic         err_noncontig;
  int           n_chk = 0;
  int           n_fail = 0;

  update_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .word_in(word_in),
    .valid_in(valid_in), .last_input_in(last_input_in), .control_in(control_in),
    .out_valid(out_valid), .out_data(out_data), .out_mask(out_mask), .out_last(out_last),
    .control_out(control_out), .line_cnt(line_cnt), .err_noncontig(err_noncontig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] seq_line(input logic [31:0] first, input int n);
    seq_line = '0;
    for (int j = 0; j < n; j++) seq_line[j*32 +: 32] = first + 32'(j);
  endfunction

  task automatic set_beat(input logic [7:0] v, input logic [31:0] first, input logic last, input logic [1:0] ctrl);
    logic [31:0] w;
    w = first;
    in_valid = 1'b1;
    valid_in = v;
    last_input_in = last;
    control_in = ctrl;
    for (int i = 0; i < 8; i++)
      if (v[i]) begin
        word_in[i*32 +: 32] = w;
        w++;
      end else word_in[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
  endtask

  task automatic beat(input logic [7:0] v, input logic [31:0] first, input logic last, input logic [1:0] ctrl);
    set_beat(v, first, last, ctrl);
    @(negedge clk);
    in_valid = 1'b0;
    valid_in = '0;
    last_input_in = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_ready", 256'(in_ready), 256'(1));
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_data", out_data, '0);
    check("rst_mask", 256'(out_mask), 256'(0));
    check("rst_cnt", 256'(line_cnt), 256'(0));
    check("rst_err", 256'(err_noncontig), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    beat(8'hF0, 32'd1, 1'b0, 2'd0);
    check("f0_b1_valid", 256'(out_valid), 256'(0));
    beat(8'hF0, 32'd5, 1'b0, 2'd1);
    check("f0_l1_valid", 256'(out_valid), 256'(1));
    check("f0_l1_data", out_data, seq_line(32'd1, 8));
    check("f0_l1_mask", 256'(out_mask), 256'(8'hFF));
    check("f0_l1_last", 256'(out_last), 256'(0));
    check("f0_l1_ctrl", 256'(control_out), 256'(1));
    beat(8'hF0, 32'd9, 1'b0, 2'd2);
    check("f0_b3_valid", 256'(out_valid), 256'(0));
    beat(8'hF0, 32'd13, 1'b0, 2'd3);
    check("f0_l2_data", out_data, seq_line(32'd9, 8));
    check("f0_l2_ctrl", 256'(control_out), 256'(3));
    check("f0_l2_cnt", 256'(line_cnt), 256'(2));
    beat(8'hE0, 32'hA1, 1'b0, 2'd0);
    beat(8'hE0, 32'hA4, 1'b0, 2'd0);
    set_beat(8'hE0, 32'hA7, 1'b1, 2'd2);
    @(negedge clk);
    check("a_l1_valid", 256'(out_valid), 256'(1));
    check("a_l1_data", out_data, seq_line(32'hA1, 8));
    check("a_l1_last", 256'(out_last), 256'(0));
    check("a_flush_ready", 256'(in_ready), 256'(0));
    set_beat(8'hFF, 32'hBAD0, 1'b0, 2'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("a_fl_valid", 256'(out_valid), 256'(1));
    check("a_fl_data", out_data, seq_line(32'hA9, 1));
    check("a_fl_mask", 256'(out_mask), 256'(8'h01));
    check("a_fl_last", 256'(out_last), 256'(1));
    check("a_fl_ctrl", 256'(control_out), 256'(2));
    check("a_fl_ready", 256'(in_ready), 256'(1));
    check("a_fl_cnt", 256'(line_cnt), 256'(4));
    beat(8'hFF, 32'h100, 1'b1, 2'd1);
    check("ff_data", out_data, seq_line(32'h100, 8));
    check("ff_mask", 256'(out_mask), 256'(8'hFF));
    check("ff_last", 256'(out_last), 256'(1));
    check("ff_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    check("ff_no_flush", 256'(out_valid), 256'(0));
    beat(8'h00, 32'h0, 1'b1, 2'd1);
    check("empty_valid", 256'(out_valid), 256'(1));
    check("empty_mask", 256'(out_mask), 256'(0));
    check("empty_last", 256'(out_last), 256'(1));
    check("empty_data", out_data, '0);
    check("empty_cnt", 256'(line_cnt), 256'(6));
    beat(8'h0A, 32'h200, 1'b0, 2'd0);
    check("nc_err", 256'(err_noncontig), 256'(1));
    beat(8'hFC, 32'h202, 1'b0, 2'd0);
    check("nc_data", out_data, seq_line(32'h200, 8));
    check("nc_err_held", 256'(err_noncontig), 256'(1));
    check("nc_cnt", 256'(line_cnt), 256'(7));
    beat(8'hF8, 32'h300, 1'b0, 2'd0);
    #2 rst = 1'b0;
    #1;
    check("ar_cnt", 256'(line_cnt), 256'(0));
    check("ar_err", 256'(err_noncontig), 256'(0));
    check("ar_mask", 256'(out_mask), 256'(0));
    check("ar_data", out_data, '0);
    check("ar_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    rst = 1'b1;
    beat(8'hFF, 32'h400, 1'b1, 2'd0);
    check("ar_fresh_data", out_data, seq_line(32'h400, 8));
    check("ar_fresh_last", 256'(out_last), 256'(1));
    check("ar_fresh_cnt", 256'(line_cnt), 256'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
